// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
//   arb_state_t : arbiter FSM states
//   M0 / M1     : master identifiers used for the last-grant record
//   AW/DW/SW    : Wishbone address, data and select widths
package wshb_arb_pkg;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 classic/registered-burst signal bundle.
//   master modport : drives cyc/stb/we/adr/dat_ms/sel/cti/bte, receives ack/err/rty/dat_sm
//   slave modport  : the reverse direction
interface wshb_if;
  import wshb_arb_pkg::*;

  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_ms;
  logic [SW-1:0] sel;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
  logic          err;
  logic          rty;
  logic [DW-1:0] dat_sm;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack, err, rty, dat_sm
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack, err, rty, dat_sm
  );

endinterface

// File: rtl/wshb_arb_watchdog.sv
// Watchdog for a granted bus cycle: counts cycles with a strobe outstanding and no ack,
// and flags a timeout on the cycle the count reaches TIMEOUT-1.
//   clk, rst   : clock, asynchronous active-high reset
//   i_active   : granted master has stb high
//   i_ack      : slave ack this cycle (clears the count)
//   i_clear    : grant changing or no grant held (clears the count)
//   o_timeout  : one-cycle abort request to the arbiter
module wshb_arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_ack,
  input  logic i_clear,
  output logic o_timeout
);

  localparam int unsigned TO_WIDTH = $clog2(TIMEOUT + 1);

  logic [TO_WIDTH-1:0] r_wdog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (i_ack || i_clear) begin
      r_wdog <= '0;
    end else if (i_active) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // Independent of ack so the abort can gate the slave strobe without a comb loop.
  assign o_timeout = i_active && (r_wdog == TO_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/wshb_arbiter_2m.sv
// Two-master Wishbone arbiter in front of a single slave. Whole bus cycles are granted
// (cyc rise to cyc fall), with round-robin or master-0 priority on simultaneous requests
// and a watchdog that aborts cycles the slave never acknowledges.
//   clk      : system clock shared by masters and slave
//   rst      : asynchronous active-high reset
//   wshb_m0  : master 0 port (video reader)
//   wshb_m1  : master 1 port (host writer)
//   wshb_s   : shared downstream port to the RAM controller
//   grant    : one-hot current grant {m1,m0}, 2'b00 when idle
module wshb_arbiter_2m
  import wshb_arb_pkg::*;
#(
  parameter bit          PRIO_M0 = 1'b1,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  wshb_if.slave       wshb_m0,
  wshb_if.slave       wshb_m1,
  wshb_if.master      wshb_s,
  output logic [1:0]  grant
);

  arb_state_t r_state;
  logic [1:0] r_grant;
  logic       r_last;
  logic [1:0] r_abort;  // master timed out, ignored until its cyc is seen low
  logic       r_kill;   // keeps slave cyc/stb low the cycle after an abort

  logic w_req0, w_req1;
  logic w_g_cyc, w_g_stb;
  logic w_in_gnt, w_to, w_leave, w_block;

  assign w_req0   = wshb_m0.cyc && !r_abort[0];
  assign w_req1   = wshb_m1.cyc && !r_abort[1];
  assign w_g_cyc  = (r_grant[0] && wshb_m0.cyc) || (r_grant[1] && wshb_m1.cyc);
  assign w_g_stb  = (r_grant[0] && wshb_m0.stb) || (r_grant[1] && wshb_m1.stb);
  assign w_in_gnt = |r_grant;
  assign w_leave  = w_in_gnt && (!w_g_cyc || w_to);
  assign w_block  = w_to || r_kill;

  wshb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_in_gnt && w_g_stb),
    .i_ack     (wshb_s.ack),
    .i_clear   (w_leave || !w_in_gnt),
    .o_timeout (w_to)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_last  <= M1;
      r_abort <= 2'b00;
      r_kill  <= 1'b0;
    end else begin
      r_kill  <= w_to;
      r_abort <= (r_abort & {wshb_m1.cyc, wshb_m0.cyc}) | (w_to ? r_grant : 2'b00);
      unique case (r_state)
        IDLE: begin
          if (w_req0 && (!w_req1 || PRIO_M0 || r_last == M1)) begin
            r_state <= GNT0;
            r_grant <= 2'b01;
          end else if (w_req1) begin
            r_state <= GNT1;
            r_grant <= 2'b10;
          end
        end
        GNT0: begin
          if (w_leave) begin
            r_last <= M0;
            // Direct handoff avoids an idle bubble when the other master is waiting.
            if (w_req1) begin
              r_state <= GNT1;
              r_grant <= 2'b10;
            end else begin
              r_state <= IDLE;
              r_grant <= 2'b00;
            end
          end
        end
        GNT1: begin
          if (w_leave) begin
            r_last <= M1;
            if (w_req0) begin
              r_state <= GNT0;
              r_grant <= 2'b01;
            end else begin
              r_state <= IDLE;
              r_grant <= 2'b00;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  assign grant = r_grant;

  // Downstream mux; everything zero while idle.
  assign wshb_s.cyc    = w_g_cyc && !w_block;
  assign wshb_s.stb    = w_g_stb && !w_block;
  assign wshb_s.we     = r_grant[1] ? wshb_m1.we     : (r_grant[0] && wshb_m0.we);
  assign wshb_s.adr    = r_grant[1] ? wshb_m1.adr    : (r_grant[0] ? wshb_m0.adr    : '0);
  assign wshb_s.dat_ms = r_grant[1] ? wshb_m1.dat_ms : (r_grant[0] ? wshb_m0.dat_ms : '0);
  assign wshb_s.sel    = r_grant[1] ? wshb_m1.sel    : (r_grant[0] ? wshb_m0.sel    : '0);
  assign wshb_s.cti    = r_grant[1] ? wshb_m1.cti    : (r_grant[0] ? wshb_m0.cti    : '0);
  assign wshb_s.bte    = r_grant[1] ? wshb_m1.bte    : (r_grant[0] ? wshb_m0.bte    : '0);

  // Responses reach only the granted master; a stale ack during an abort is dropped.
  assign wshb_m0.ack    = r_grant[0] && wshb_s.ack && !w_block;
  assign wshb_m0.rty    = r_grant[0] && wshb_s.rty && !w_block;
  assign wshb_m0.err    = r_grant[0] && ((wshb_s.err && !w_block) || w_to);
  assign wshb_m1.ack    = r_grant[1] && wshb_s.ack && !w_block;
  assign wshb_m1.rty    = r_grant[1] && wshb_s.rty && !w_block;
  assign wshb_m1.err    = r_grant[1] && ((wshb_s.err && !w_block) || w_to);
  assign wshb_m0.dat_sm = wshb_s.dat_sm;
  assign wshb_m1.dat_sm = wshb_s.dat_sm;

endmodule

// File: tb/tb_wshb_arbiter_2m.sv
// Directed bench for wshb_arbiter_2m with a small RAM slave model (fixed ack latency,
// optional hang) behind it.
module tb_wshb_arbiter_2m;
  import wshb_arb_pkg::*;

  localparam int unsigned LAT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       hang;
  int         checks = 0;
  int         errors = 0;
  int         m0_acks = 0;
  int         m1_acks = 0;

  wshb_if m0_if ();
  wshb_if m1_if ();
  wshb_if s_if ();

  always #5 clk = ~clk;

  wshb_arbiter_2m #(
    .PRIO_M0 (1'b0),
    .TIMEOUT (64)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wshb_m0 (m0_if),
    .wshb_m1 (m1_if),
    .wshb_s  (s_if),
    .grant   (grant)
  );

  // RAM slave model: acks LAT+1 cycles after a strobe appears, one ack per beat.
  logic [31:0] mem [0:1023];
  int          lat_cnt;
  assign s_if.err = 1'b0;
  assign s_if.rty = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_if.ack    <= 1'b0;
      s_if.dat_sm <= '0;
      lat_cnt     <= 0;
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (s_if.ack) begin
      s_if.ack <= 1'b0;
      lat_cnt  <= 0;
    end else if (s_if.cyc && s_if.stb && !hang) begin
      if (lat_cnt == LAT - 1) begin
        s_if.ack <= 1'b1;
        lat_cnt  <= 0;
        if (s_if.we) mem[s_if.adr[9:0]] <= s_if.dat_ms;
        else         s_if.dat_sm <= mem[s_if.adr[9:0]];
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (m0_if.ack) m0_acks++;
    if (m1_if.ack) m1_acks++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_if.ack : m1_if.ack;
  endfunction

  task automatic drive(input int m, input logic cyc, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat);
    if (m == 0) begin
      m0_if.cyc = cyc; m0_if.stb = cyc; m0_if.we = we; m0_if.adr = adr; m0_if.dat_ms = dat;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = cyc; m1_if.we = we; m1_if.adr = adr; m1_if.dat_ms = dat;
    end
  endtask

  // One bus cycle of n beats; write data is dat+i, read data of first and last beat returned.
  task automatic bus(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input int n, output logic [31:0] rd0, output logic [31:0] rdl);
    int t;
    rd0 = '0;
    rdl = '0;
    @(negedge clk);
    drive(m, 1'b1, we, adr, dat);
    for (int i = 0; i < n; i++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!ack_of(m) && t < 200);
      chk($sformatf("ack_m%0d_beat%0d", m, i), {31'b0, ack_of(m)}, 32'd1);
      if (!ack_of(m)) break;
      if (i == 0) rd0 = (m == 0) ? m0_if.dat_sm : m1_if.dat_sm;
      rdl = (m == 0) ? m0_if.dat_sm : m1_if.dat_sm;
      drive(m, 1'b1, we, adr + 32'(i) + 1, dat + 32'(i) + 1);
    end
    drive(m, 1'b0, 1'b0, '0, '0);
    #1;
  endtask

  initial begin
    logic [31:0] r0, rl, r2, r3, r4, r5;
    int a0, a1, t, ngr, alt_bad;
    logic [1:0] prev, cur;
    logic stop;

    hang = 1'b0;
    m0_if.sel = 4'hF; m0_if.cti = 3'b000; m0_if.bte = 2'b00;
    m1_if.sel = 4'hF; m1_if.cti = 3'b000; m1_if.bte = 2'b00;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", {30'b0, grant}, 32'd0);
    chk("rst_s_cyc", {31'b0, s_if.cyc}, 32'd0);
    chk("rst_m0_ack", {31'b0, m0_if.ack}, 32'd0);
    chk("rst_m1_ack", {31'b0, m1_if.ack}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // M1 single write; grant appears the cycle after cyc
    a0 = m0_acks; a1 = m1_acks;
    fork
      bus(1, 1'b1, 32'h10, 32'hCAFE_BABE, 1, r0, rl);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("wr_grant", {30'b0, grant}, 32'd2);
        chk("wr_s_adr", s_if.adr, 32'h10);
        chk("wr_s_we", {31'b0, s_if.we}, 32'd1);
      end
    join
    chk("wr_m1_acks", m1_acks - a1, 32'd1);
    chk("wr_m0_acks", m0_acks - a0, 32'd0);

    bus(0, 1'b0, 32'h10, 32'h0, 1, r0, rl);
    chk("rd_back", r0, 32'hCAFE_BABE);
    bus(1, 1'b1, 32'h30, 32'h1234_5678, 1, r0, rl);   // leaves last=M1

    // Simultaneous request: M0 burst first, then M1 with no idle cycle
    a0 = m0_acks; a1 = m1_acks;
    fork
      begin
        bus(0, 1'b0, 32'h30, 32'h0, 8, r0, rl);
        chk("burst_first", r0, 32'h1234_5678);
        chk("burst_last", rl, 32'hA500_0037);
        chk("burst_m0_acks", m0_acks - a0, 32'd8);
        chk("burst_m1_acks", m1_acks - a1, 32'd0);
        @(negedge clk);
        chk("handoff_grant", {30'b0, grant}, 32'd2);
      end
      bus(1, 1'b1, 32'h38, 32'hDEAD_BEEF, 1, r2, r3);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("tie_grant", {30'b0, grant}, 32'd1);
      end
    join
    chk("tie_m1_acks", m1_acks - a1, 32'd1);

    // M1 holds cyc over 3 writes while M0 waits
    a0 = m0_acks; a1 = m1_acks;
    fork
      begin
        bus(1, 1'b1, 32'h50, 32'hD000_0000, 3, r2, r3);
        chk("hold_m0_acks", m0_acks - a0, 32'd0);
        chk("hold_m1_acks", m1_acks - a1, 32'd3);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        bus(0, 1'b0, 32'h52, 32'h0, 1, r4, r5);
        chk("hold_rd", r4, 32'hD000_0002);
      end
    join

    // Hung slave: err 64 cycles after stb, grant dropped, aborted master ignored
    @(negedge clk);
    hang = 1'b1;
    drive(1, 1'b1, 1'b1, 32'h60, 32'h0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!m1_if.err && t < 200);
    chk("wdog_latency", t, 32'd64);
    chk("wdog_s_cyc", {31'b0, s_if.cyc}, 32'd0);
    chk("wdog_grant", {30'b0, grant}, 32'd2);
    @(negedge clk);
    chk("wdog_err_len", {31'b0, m1_if.err}, 32'd0);
    chk("wdog_release", {30'b0, grant}, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_ignored", {30'b0, grant}, 32'd0);
    drive(1, 1'b0, 1'b0, '0, '0);
    hang = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a burst
    drive(0, 1'b1, 1'b0, 32'h30, 32'h0);
    repeat (4) @(negedge clk);
    chk("pre_rst_grant", {30'b0, grant}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_grant", {30'b0, grant}, 32'd0);
    chk("mid_rst_s_cyc", {31'b0, s_if.cyc}, 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_m0_ack", {31'b0, m0_if.ack}, 32'd0);
    chk("post_rst_m1_ack", {31'b0, m1_if.ack}, 32'd0);

    // Both masters re-request continuously; grants must alternate
    stop = 1'b0; alt_bad = 0; ngr = 0; prev = 2'b00; cur = 2'b00;
    fork
      while (!stop) bus(0, 1'b0, 32'h70, 32'h0, 1, r0, rl);
      while (!stop) bus(1, 1'b1, 32'h71, 32'h1, 1, r2, r3);
      begin
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (grant != 2'b00 && grant != cur) begin
            if (grant == prev) alt_bad++;
            prev = grant;
            ngr++;
          end
          cur = grant;
        end
        stop = 1'b1;
      end
    join
    chk("alt_repeats", alt_bad, 32'd0);
    chk("alt_grants", ngr, 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
